// File: rtl/reval_datapath.sv
// -----------------------------------------------------------------------------
// reval_datapath
//
// Datapath stage that sits directly behind the revaluate controller. During a
// pass it walks a DEPTH-entry input memory in address order, evaluates each
// element against THRESHOLD and streams the evaluated value to an output
// memory. A hit count and a sum are accumulated over the pass. On the final
// write both are latched into result registers, which then survive the
// controller's return to IDLE.
//
// Optional build macro:
//   REVAL_MAX_EN - adds res_max / res_max_idx. They hold the largest element
//                  of the last completed pass and its lowest index.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   dataset_reset     synchronous clear of pass state (controller IDLE)
//   write, count      controller enables (START: write; COUNT: write & count)
//   rd_addr, rd_data  input-memory read port (sync read, 1-cycle latency)
//   wr_en, wr_addr,   output-memory write port carrying the evaluated element
//   wr_data
//   datapath_done     last element is being written this cycle
//   res_hits, res_sum latched totals of the last completed pass
//   res_valid         res_* hold a completed pass
// -----------------------------------------------------------------------------
module reval_datapath #(
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 8,
    parameter int THRESHOLD = 10,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dataset_reset,
    input  logic                     write,
    input  logic                     count,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     datapath_done,
    output logic [ADDR_W:0]          res_hits,
    output logic [DATA_W+ADDR_W-1:0] res_sum,
    output logic                     res_valid
`ifdef REVAL_MAX_EN
    ,
    output logic [DATA_W-1:0]        res_max,
    output logic [ADDR_W-1:0]        res_max_idx
`endif
);

    localparam int                SUM_W     = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] THR       = DATA_W'(THRESHOLD);

    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [ADDR_W:0]   hits_q,      hits_d;
    logic [SUM_W-1:0]  sum_q,       sum_d;
    logic              finished_q,  finished_d;
    logic [ADDR_W:0]   res_hits_q,  res_hits_d;
    logic [SUM_W-1:0]  res_sum_q,   res_sum_d;
    logic              res_valid_q, res_valid_d;

    logic              active;
    logic              at_last;
    logic              hit;
    logic [DATA_W-1:0] eval;
    logic [ADDR_W:0]   hits_next;
    logic [SUM_W-1:0]  sum_next;

    // A write happens only in a legal COUNT cycle of an unfinished pass.
    // write=0 with count=1 falls out as a no-op.
    assign active  = write & count & ~finished_q;
    assign at_last = (addr_q == LAST_ADDR);

    assign hit  = (rd_data > THR);
    assign eval = hit ? (rd_data - THR) : '0;

    // While counting, look one address ahead so that the sync-read data for
    // addr+1 arrives together with the advanced address. Saturate at the end.
    assign rd_addr = (count && !at_last) ? (addr_q + ADDR_W'(1)) : addr_q;

    assign wr_en         = active;
    assign wr_addr       = addr_q;
    assign wr_data       = eval;
    assign datapath_done = count & ~finished_q & at_last;

    // The totals that include this cycle's element. The final write latches
    // them directly so the result does not need an extra cycle.
    assign hits_next = hits_q + (ADDR_W + 1)'(hit);
    assign sum_next  = sum_q + SUM_W'(eval);

    assign res_hits  = res_hits_q;
    assign res_sum   = res_sum_q;
    assign res_valid = res_valid_q;

`ifdef REVAL_MAX_EN
    logic [DATA_W-1:0] max_q,         max_d;
    logic [ADDR_W-1:0] max_idx_q,     max_idx_d;
    logic [DATA_W-1:0] res_max_q,     res_max_d;
    logic [ADDR_W-1:0] res_max_idx_q, res_max_idx_d;
    logic              new_max;
    logic [DATA_W-1:0] max_next;
    logic [ADDR_W-1:0] max_idx_next;

    // Strict compare: on a tie the earlier (lower) index is kept.
    assign new_max      = (rd_data > max_q);
    assign max_next     = new_max ? rd_data : max_q;
    assign max_idx_next = new_max ? addr_q  : max_idx_q;

    assign res_max     = res_max_q;
    assign res_max_idx = res_max_idx_q;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through this block leaves a variable unassigned (no latch inferred).
        addr_d      = addr_q;
        hits_d      = hits_q;
        sum_d       = sum_q;
        finished_d  = finished_q;
        res_hits_d  = res_hits_q;
        res_sum_d   = res_sum_q;
        res_valid_d = res_valid_q;
`ifdef REVAL_MAX_EN
        max_d         = max_q;
        max_idx_d     = max_idx_q;
        res_max_d     = res_max_q;
        res_max_idx_d = res_max_idx_q;
`endif

        if (dataset_reset) begin
            // The results of the previous pass are deliberately kept.
            addr_d     = '0;
            hits_d     = '0;
            sum_d      = '0;
            finished_d = 1'b0;
`ifdef REVAL_MAX_EN
            max_d      = '0;
            max_idx_d  = '0;
`endif
        end else if (active) begin
            hits_d = hits_next;
            sum_d  = sum_next;
`ifdef REVAL_MAX_EN
            max_d     = max_next;
            max_idx_d = max_idx_next;
`endif
            if (!at_last) begin
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                finished_d  = 1'b1;
                res_hits_d  = hits_next;
                res_sum_d   = sum_next;
                res_valid_d = 1'b1;
`ifdef REVAL_MAX_EN
                res_max_d     = max_next;
                res_max_idx_d = max_idx_next;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            hits_q      <= '0;
            sum_q       <= '0;
            finished_q  <= 1'b0;
            res_hits_q  <= '0;
            res_sum_q   <= '0;
            res_valid_q <= 1'b0;
`ifdef REVAL_MAX_EN
            max_q         <= '0;
            max_idx_q     <= '0;
            res_max_q     <= '0;
            res_max_idx_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments make all registers update together
            // from the values they had before the edge.
            addr_q      <= addr_d;
            hits_q      <= hits_d;
            sum_q       <= sum_d;
            finished_q  <= finished_d;
            res_hits_q  <= res_hits_d;
            res_sum_q   <= res_sum_d;
            res_valid_q <= res_valid_d;
`ifdef REVAL_MAX_EN
            max_q         <= max_d;
            max_idx_q     <= max_idx_d;
            res_max_q     <= res_max_d;
            res_max_idx_q <= res_max_idx_d;
`endif
        end
    end

endmodule

// File: doc/reval_datapath.md
Name: reval_datapath

Overview:
- Datapath stage directly downstream of the revaluate controller. It consumes dataset_reset, write and count, and returns datapath_done.
- Walks a DEPTH-entry input memory in address order. Each element is evaluated against THRESHOLD, and the evaluated value is written to an output memory.
- Accumulates a hit count and a sum over the pass. Both are latched into result registers that survive the controller's return to IDLE.

Parameters:
- DEPTH, 16, number of dataset entries (>= 2).
- DATA_W, 8, element width (unsigned).
- THRESHOLD, 10, evaluation threshold (unsigned, < 2^DATA_W).
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- dataset_reset  in  1  synchronous clear of pass state (controller IDLE)
- write  in  1  controller write enable (START and COUNT)
- count  in  1  controller count enable (COUNT only)
- rd_addr  out  ADDR_W  input-memory read address (sync-read memory, 1-cycle latency)
- rd_data  in  DATA_W  input-memory read data
- wr_en  out  1  output-memory write strobe
- wr_addr  out  ADDR_W  output-memory write address
- wr_data  out  DATA_W  evaluated element
- datapath_done  out  1  last element is being written this cycle
- res_hits  out  ADDR_W+1  latched hit count of last completed pass
- res_sum  out  DATA_W+ADDR_W  latched sum of last completed pass
- res_valid  out  1  res_* hold a completed pass

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On rst, addr, hits, sum, finished, res_hits, res_sum and res_valid all go to 0.
- dataset_reset (sync, priority over count): clears addr, hits, sum and finished. res_* are NOT cleared.
- Read address:
  - rd_addr = addr when count=0; min(addr+1, DEPTH-1) when count=1 (combinational).
  - During START (write=1, count=0) mem[0] is pre-fetched.
  - In every COUNT cycle with addr=k, rd_data = mem[k].
- Evaluation (combinational):
  - hit = rd_data > THRESHOLD.
  - wr_data = hit ? rd_data - THRESHOLD : 0.
- Writes:
  - wr_en = write & count & ~finished.
  - wr_addr = addr.
  - Zero added latency; the write lands on the same edge that advances addr.
- Per active COUNT cycle, at the clock edge:
  - hits += hit; sum += wr_data (width cannot overflow).
  - addr += 1 if addr < DEPTH-1.
- datapath_done = count & ~finished & (addr == DEPTH-1), combinational. The controller samples it and moves to DONE on the same edge.
- On the edge of the final write:
  - finished <= 1.
  - res_hits <= hits + hit; res_sum <= sum + wr_data; res_valid <= 1.
- After finished: count is ignored (no write, no addr change, datapath_done=0) until dataset_reset.
- write=0 with count=1 is illegal; treat it as no-op (wr_en low, no state change).
- rst mid-pass: all state and results are cleared immediately. The pass is abandoned and no partial results are latched.

Optional Feature:
- Macro REVAL_MAX_EN.
- Defined: adds outputs res_max (DATA_W) and res_max_idx (ADDR_W).
  - A running max of rd_data is kept; ties keep the lower index.
  - It is cleared by rst and dataset_reset, and latched with the other res_* on the final write.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- DEPTH=4, THRESHOLD=10, mem={5,20,10,255}, one start pass -> writes {0,10,0,245} at addr 0..3 on 4 consecutive COUNT cycles; datapath_done high only in 4th; res_hits=2, res_sum=255, res_valid=1.
- Same pass, then controller held in IDLE 10 cycles -> res_* unchanged (2, 255); addr=0, no wr_en.
- All elements = THRESHOLD (10) -> all wr_data=0, res_hits=0, res_sum=0, res_valid=1.
- All elements = 255, DEPTH=16 -> res_hits=16, res_sum=16*245=3920 (no overflow).
- rst asserted during 2nd COUNT cycle -> all outputs 0 immediately, res_valid=0; a new pass afterwards completes normally.
- Force count high for 3 extra cycles after the final write -> no wr_en, datapath_done stays 0, addr holds at 3. With REVAL_MAX_EN: mem={7,9,9,3} -> res_max=9, res_max_idx=1.
